regfile_mp_sb: RTL and testbench
================================

// Module: regfile_mp_sb
// PURPOSE
//  Parametrised multi-port integer register file for the next core generation: NUM_RD combinational read
//  ports with same-cycle write bypass, NUM_WR writeback ports, a per-register pending scoreboard for
//  hazard detection, and an arbitrated debug (JTAG) access port with req/ack handshake and core stall.
//  Sits between decode/issue (reads, pending-set) and the writeback stages (writes, pending-clear).
// PARAMETERS
//  DATA_WIDTH    32  register width in bits
//  ADDR_WIDTH    5   register index width; DEPTH = 2**ADDR_WIDTH
//  NUM_RD        2   read ports
//  NUM_WR        2   write ports; higher index = younger instruction
//  STARVE_LIMIT  8   debug wait cycles before the core is stalled (>=1)
// PORTS
//  clk        in   1                    clock, all state on rising edge
//  rst        in   1                    asynchronous, active-high reset
//  rd_addr    in   NUM_RD*ADDR_WIDTH    read indices, port p at [p*AW +: AW]
//  rd_data    out  NUM_RD*DATA_WIDTH    read data, combinational
//  rd_busy    out  NUM_RD               register still awaiting writeback
//  wr_en      in   NUM_WR               writeback valid per port
//  wr_addr    in   NUM_WR*ADDR_WIDTH    writeback indices
//  wr_data    in   NUM_WR*DATA_WIDTH    writeback data
//  iss_en     in   1                    instruction issued with destination iss_rd
//  iss_rd     in   ADDR_WIDTH           destination to mark pending
//  dbg_req    in   1                    debug request, held until dbg_ack
//  dbg_we     in   1                    1 = write, 0 = read; stable while dbg_req
//  dbg_addr   in   ADDR_WIDTH           debug register index
//  dbg_wdata  in   DATA_WIDTH           debug write data
//  dbg_ack    out  1                    one-cycle completion pulse
//  dbg_rdata  out  DATA_WIDTH           register value at grant (pre-write), valid with dbg_ack
//  allow_in   out  1                    core may issue/write back; low = stall
// BEHAVIOUR
//  Reset: all registers 0, pending bits 0, dbg_ack 0, dbg_rdata 0, allow_in 0, FSM IDLE. allow_in rises on
//   first clock edge after rst deasserts. Reset mid-debug: access abandoned, no ack, no write.
//  Register 0: never written (core or debug), reads 0, never pending, rd_busy 0.
//  Writes: committed at clock edge. Same address on several enabled ports: highest port index wins.
//  Reads: rd_data[p] = wr_data of highest-index enabled port with wr_addr == rd_addr[p], else array value.
//  Scoreboard: pend[r] cleared at edge by any enabled write to r; set by iss_en to iss_rd.
//   Set and clear of same r in one cycle: set wins. rd_busy[p] = pend[rd_addr[p]] & ~(any write hit this cycle).
//  Debug FSM: IDLE -> WAIT on dbg_req. Grant in any cycle (WAIT or STALL) with wr_en == 0:
//   dbg_rdata <= array[dbg_addr] (0 for index 0), write performed if dbg_we, next state ACK.
//   WAIT counts cycles; after STARVE_LIMIT ungranted cycles -> STALL, allow_in = 0 until grant.
//   ACK: dbg_ack = 1 for exactly one cycle, allow_in back to 1, -> IDLE (new req accepted next cycle).
//   Debug write does not alter pend bits. Earliest ack: 2 cycles after dbg_req rises.
//  Core must hold wr_en low while allow_in = 0 only for new writebacks; in-flight writes drain first.
// STRUCTURE
//  Shared package/include: DATA_WIDTH, ADDR_WIDTH defaults, debug FSM state encodings (IDLE/WAIT/STALL/ACK).
//  One sub-module: regfile_bypass_mux (per read port priority select over NUM_WR writes), instantiated NUM_RD times.
//  Array, scoreboard and debug FSM stay in top level; generate loops over ports.
// TESTING
//  1 Reset release: rst 1->0 -> allow_in 0 then 1 next edge; all reads of x1..x31 return 0, rd_busy 0.
//  2 wr_en=2'b11, both addr 5, data A/B -> same-cycle read of x5 returns B; next cycle array x5 = B.
//  3 iss_en rd=7 -> rd_busy for x7 = 1; later wr x7 = 0x55 and iss_en rd=7 same cycle -> x7 = 0x55, still busy.
//  4 Writes to x0 on every port and via debug -> x0 reads 0, rd_busy 0.
//  5 dbg read x3 (=0x1234) with wr_en idle -> dbg_ack 2 cycles after req, dbg_rdata 0x1234, allow_in stays 1.
//  6 dbg write x4 with wr_en held busy >STARVE_LIMIT -> allow_in 0, grant once wr_en drops, x4 updated, ack, allow_in 1.

Source files
------------

// File: rtl/regfile_mp_sb_pkg.sv
// Shared defaults and debug-port FSM encodings for the multi-port register file.
package regfile_mp_sb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_STALL = 2'd2,
    ST_ACK   = 2'd3
  } dbg_state_t;

endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port bypass: picks the youngest same-cycle writeback to the read index, else the array value.
module regfile_bypass_mux
  import regfile_mp_sb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_WR     = 2
) (
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic [DATA_WIDTH-1:0]        arr_data,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         hit
);

  // Ascending scan so the highest-index (youngest) matching port is the last to override.
  // Index 0 is hard-wired, so writes to it never forward.
  always_comb begin
    rd_data = arr_data;
    hit     = 1'b0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && (wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr) && (rd_addr != '0)) begin
        rd_data = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
        hit     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write bypass, pending scoreboard and arbitrated debug access.
module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int NUM_RD       = 2,
  parameter int NUM_WR       = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic                         iss_en,
  input  logic [ADDR_WIDTH-1:0]        iss_rd,
  input  logic                         dbg_req,
  input  logic                         dbg_we,
  input  logic [ADDR_WIDTH-1:0]        dbg_addr,
  input  logic [DATA_WIDTH-1:0]        dbg_wdata,
  output logic                         dbg_ack,
  output logic [DATA_WIDTH-1:0]        dbg_rdata,
  output logic                         allow_in
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      pend;
  logic [DEPTH-1:0]      pend_set;
  logic [DEPTH-1:0]      pend_clr;
  dbg_state_t            state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  grant;
  logic                  run;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic                  hit;
    assign addr = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

    regfile_bypass_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_WR     (NUM_WR)
    ) u_mux (
      .rd_addr  (addr),
      .arr_data (regs[addr]),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .hit      (hit)
    );

    assign rd_busy[p] = pend[addr] & ~hit;
  end

  // Later ports assign last, so the youngest writer wins on an address collision.
  // Debug writes only happen on grant, which requires all writeback ports idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] != '0))
          regs[wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data[w*DATA_WIDTH +: DATA_WIDTH];
      end
      if (grant && dbg_we && (dbg_addr != '0))
        regs[dbg_addr] <= dbg_wdata;
    end
  end

  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w]) pend_clr[wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
    end
    if (iss_en) pend_set[iss_rd] = 1'b1;
    pend_set[0] = 1'b0;
  end

  // Set is applied after clear so a same-cycle reissue keeps the register pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= (pend & ~pend_clr) | pend_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      run       <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      run   <= 1'b1;
      if (grant) dbg_rdata <= regs[dbg_addr];
    end
  end

  // Grant needs a cycle with no writeback so the array port is free and the read is pre-write.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grant     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dbg_req) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT: begin
        if (wr_en == '0) begin
          grant     = 1'b1;
          state_nxt = ST_ACK;
        end else if (cnt == CNT_W'(STARVE_LIMIT - 1)) begin
          state_nxt = ST_STALL;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_STALL: begin
        if (wr_en == '0) begin
          grant     = 1'b1;
          state_nxt = ST_ACK;
        end
      end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign dbg_ack  = (state == ST_ACK);
  assign allow_in = run & (state != ST_STALL);

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: reset, bypass priority, scoreboard, x0 handling and debug port.
module tb_regfile_mp_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_rd;
  logic        dbg_req;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        allow_in;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_mp_sb #(
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (5),
    .NUM_RD       (2),
    .NUM_WR       (2),
    .STARVE_LIMIT (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_en    (iss_en),
    .iss_rd    (iss_rd),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .allow_in  (allow_in)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en   = 2'b01;
    wr_addr = {5'd0, a};
    wr_data = {32'd0, d};
    @(negedge clk);
    wr_en = 2'b00;
  endtask

  task automatic wait_ack(input string tag, input int budget);
    int k;
    k = 0;
    while (dbg_ack !== 1'b1 && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(tag, {63'd0, dbg_ack}, 64'd1);
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_rd = '0; dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    // Reset and release
    repeat (2) @(posedge clk);
    #1;
    chk("rst_allow", {63'd0, allow_in}, 64'd0);
    chk("rst_ack",   {63'd0, dbg_ack},  64'd0);
    chk("rst_rdata", {32'd0, dbg_rdata}, 64'd0);
    @(negedge clk) rst = 1'b0;
    #1 chk("rel_allow_pre", {63'd0, allow_in}, 64'd0);
    @(posedge clk);
    #1 chk("rel_allow_post", {63'd0, allow_in}, 64'd1);
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      rd_addr = {5'(r), 5'(r)};
      #1;
      chk("rst_rd_data", rd_data, 64'd0);
      chk("rst_rd_busy", {62'd0, rd_busy}, 64'd0);
    end

    // Same-address dual write: port 1 wins
    @(negedge clk);
    wr_en = 2'b11; wr_addr = {5'd5, 5'd5}; wr_data = {32'hBBBB0002, 32'hAAAA0001};
    rd_addr = {5'd6, 5'd5};
    #1;
    chk("byp_x5_p0", {32'd0, rd_data[31:0]},  {32'd0, 32'hBBBB0002});
    chk("byp_x6_p1", {32'd0, rd_data[63:32]}, 64'd0);
    @(negedge clk);
    wr_en = 2'b00;
    #1 chk("arr_x5", {32'd0, rd_data[31:0]}, {32'd0, 32'hBBBB0002});

    // Distinct addresses on the two ports
    @(negedge clk);
    wr_en = 2'b11; wr_addr = {5'd8, 5'd9}; wr_data = {32'hC0C0C0C0, 32'hD0D0D0D0};
    rd_addr = {5'd9, 5'd8};
    #1;
    chk("byp_x8", {32'd0, rd_data[31:0]},  {32'd0, 32'hC0C0C0C0});
    chk("byp_x9", {32'd0, rd_data[63:32]}, {32'd0, 32'hD0D0D0D0});
    @(negedge clk);
    wr_en = 2'b00;

    // Scoreboard: set, same-cycle set+clear, plain clear
    iss_en = 1'b1; iss_rd = 5'd7;
    @(negedge clk);
    iss_en = 1'b0; rd_addr = {5'd7, 5'd5};
    #1;
    chk("busy_x7",  {63'd0, rd_busy[1]}, 64'd1);
    chk("busy_x5",  {63'd0, rd_busy[0]}, 64'd0);
    @(negedge clk);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'd0, 32'h55};
    iss_en = 1'b1; iss_rd = 5'd7;
    #1;
    chk("busy_x7_hit", {63'd0, rd_busy[1]}, 64'd0);
    chk("byp_x7",      {32'd0, rd_data[63:32]}, {32'd0, 32'h55});
    @(negedge clk);
    wr_en = 2'b00; iss_en = 1'b0;
    #1;
    chk("x7_val",      {32'd0, rd_data[63:32]}, {32'd0, 32'h55});
    chk("busy_x7_set", {63'd0, rd_busy[1]}, 64'd1);
    wr1(5'd7, 32'h66);
    #1 chk("busy_x7_clr", {63'd0, rd_busy[1]}, 64'd0);

    // x0 writes on both ports plus issue to x0
    @(negedge clk);
    wr_en = 2'b11; wr_addr = {5'd0, 5'd0}; wr_data = {32'hFFFFFFFF, 32'hEEEEEEEE};
    iss_en = 1'b1; iss_rd = 5'd0; rd_addr = {5'd0, 5'd0};
    #1 chk("x0_byp", rd_data, 64'd0);
    @(negedge clk);
    wr_en = 2'b00; iss_en = 1'b0;
    #1;
    chk("x0_arr",  rd_data, 64'd0);
    chk("x0_busy", {62'd0, rd_busy}, 64'd0);

    // Debug read x3 with idle writeback
    wr1(5'd3, 32'h1234);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd3;
    @(posedge clk);
    #1;
    chk("dbgr_ack1",   {63'd0, dbg_ack},  64'd0);
    chk("dbgr_allow1", {63'd0, allow_in}, 64'd1);
    @(posedge clk);
    #1;
    chk("dbgr_ack2",   {63'd0, dbg_ack},   64'd1);
    chk("dbgr_rdata",  {32'd0, dbg_rdata}, {32'd0, 32'h1234});
    chk("dbgr_allow2", {63'd0, allow_in},  64'd1);
    @(negedge clk) dbg_req = 1'b0;
    @(posedge clk);
    #1 chk("dbgr_ack_pulse", {63'd0, dbg_ack}, 64'd0);

    // Debug write to x0 is dropped
    @(negedge clk);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd0; dbg_wdata = 32'hFF;
    wait_ack("dbg_x0_ack", 10);
    chk("dbg_x0_rdata", {32'd0, dbg_rdata}, 64'd0);
    @(negedge clk);
    dbg_req = 1'b0; rd_addr = {5'd0, 5'd0};
    @(negedge clk);
    #1 chk("dbg_x0_rd", rd_data, 64'd0);

    // Debug write x4 starved by continuous writeback
    wr1(5'd4, 32'h44);
    @(negedge clk);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd10}; wr_data = {32'd0, 32'h1010};
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd4; dbg_wdata = 32'hCAFE;
    rd_addr = {5'd4, 5'd4};
    @(posedge clk);
    repeat (7) @(posedge clk);
    #1 chk("starve_allow_pre", {63'd0, allow_in}, 64'd1);
    @(posedge clk);
    #1 chk("starve_allow_stall", {63'd0, allow_in}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("starve_hold",  {63'd0, allow_in}, 64'd0);
    chk("starve_noack", {63'd0, dbg_ack},  64'd0);
    chk("starve_x4_old", {32'd0, rd_data[31:0]}, {32'd0, 32'h44});
    @(negedge clk) wr_en = 2'b00;
    @(posedge clk);
    #1;
    chk("starve_ack",   {63'd0, dbg_ack},   64'd1);
    chk("starve_rdata", {32'd0, dbg_rdata}, {32'd0, 32'h44});
    chk("starve_allow", {63'd0, allow_in},  64'd1);
    @(negedge clk) dbg_req = 1'b0;
    #1 chk("starve_x4_new", {32'd0, rd_data[31:0]}, {32'd0, 32'hCAFE});

    // Reset while a debug access is pending
    @(negedge clk);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd11};
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd12; dbg_wdata = 32'hBEEF;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("mid_rst_ack",   {63'd0, dbg_ack},  64'd0);
    chk("mid_rst_allow", {63'd0, allow_in}, 64'd0);
    wr_en = 2'b00; dbg_req = 1'b0; rd_addr = {5'd12, 5'd4};
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_allow1", {63'd0, allow_in}, 64'd1);
    chk("mid_rst_noack",  {63'd0, dbg_ack},  64'd0);
    chk("mid_rst_regs",   rd_data, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
